fifo_vc_rr: RTL and testbench
=============================

FIFO_VC_RR -- requirements
Module: fifo_vc_rr

Interface
REQ-001 Parameter DW, default 16, data width in bits.
REQ-002 Parameter L, default 8, depth per channel in words (L >= 2, any integer).
REQ-003 Parameter VN, default 4, number of virtual channels (VN >= 2); VCW = max(1, clog2(VN)) derived locally.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 d_in  input  DW  write data.
REQ-007 vc_in  input  VCW  target channel of write.
REQ-008 req_in  input  1  writer offers d_in.
REQ-009 ack_in  output  1  block accepts; write occurs when req_in & ack_in at rising clk.
REQ-010 d_out  output  DW  head word of granted channel.
REQ-011 vc_out  output  VCW  granted channel index.
REQ-012 req_out  output  1  d_out/vc_out valid.
REQ-013 ack_out  input  1  reader accepts; pop occurs when req_out & ack_out at rising clk.

Function
REQ-014 Each channel SHALL be an independent L-entry FIFO with read pointer, write pointer and count of clog2(L+1) bits; pointers wrap from L-1 to 0.
REQ-015 ack_in SHALL equal rstn & (vc_in < VN) & (count[vc_in] != L), combinational, independent of req_in.
REQ-016 Out-of-range vc_in SHALL never write and SHALL not disturb any channel.
REQ-017 A word written at edge k SHALL be eligible for output from edge k (visible on req_out during cycle k+1); no same-cycle bypass.
REQ-018 req_out SHALL be 1 iff the granted channel is non-empty; d_out/vc_out SHALL be undefined-don't-care when req_out=0 but driven to the granted channel's head.
REQ-019 Grant selection: first non-empty channel scanning rr_ptr, rr_ptr+1, ... modulo VN.
REQ-020 Grant lock: once req_out=1 with ack_out=0, vc_out and d_out SHALL hold unchanged until the pop, regardless of new writes to other channels.
REQ-021 After a pop from channel g, rr_ptr SHALL become (g+1) mod VN and the lock SHALL clear.
REQ-022 Push and pop on the same channel in one cycle SHALL leave count unchanged; on a full channel the push is refused by REQ-015 (no pass-through).
REQ-023 Per-channel order SHALL be strictly first-in first-out; no word duplicated or dropped.

Reset
REQ-024 rstn low SHALL immediately clear all counts, pointers, rr_ptr (0) and lock; req_out=0 and ack_in=0 while rstn low.
REQ-025 Storage array contents need no reset; after release ack_in=1 for any valid vc_in, req_out=0.
REQ-026 Reset asserted mid-transfer SHALL discard all stored words; no pop or push completes at that edge.

Configuration
REQ-027 Macro FIFO_VC_STATUS_EN: when defined, extra outputs full[VN-1:0] and empty[VN-1:0] SHALL reflect count==L and count==0 per channel (reset: full=0, empty=all ones); when undefined these ports and their logic SHALL be absent and all other behaviour identical.

Verification (DW=16, L=8, VN=4)
REQ-028 Reset, ack_out=0, write 8 words to vc 1 -> 9th offer on vc 1 sees ack_in=0 while vc_in=2 sees ack_in=1.
REQ-029 Write 0x00A0..0x00A3 to vc 0..3, then ack_out=1 -> vc_out sequence 0,1,2,3 with matching data, then req_out=0.
REQ-030 vc 2 holds 0x0022 offered with ack_out=0, write 0x0000 to vc 0 -> vc_out stays 2, d_out 0x0022 until ack_out=1; next grant vc 0.
REQ-031 Random interleaved writes to vc 3 of 0x1111,0x2222,0x3333 with other-channel traffic -> vc 3 outputs in that order; scoreboard per channel reports zero mismatches over 1000 random cycles.
REQ-032 5 words in vc 0, pull rstn low asynchronously between edges -> req_out=0 and ack_in=0 immediately; after release req_out stays 0 and vc 0 accepts 8 new words.
REQ-033 vc 1 full (8 words), same cycle req_in on vc 1 and pop of vc 1 -> write refused; next cycle ack_in=1 and count=7; with FIFO_VC_STATUS_EN full[1] goes 1->0.

Source files
------------

// File: rtl/fifo_vc_rr.sv
// rtl/fifo_vc_rr.sv - per-channel FIFOs sharing one output with a locking round-robin grant
// Optional per-channel full/empty status outputs: FIFO_VC_STATUS_EN
module fifo_vc_rr #(
    parameter int DW = 16,
    parameter int L  = 8,
    parameter int VN = 4,
    localparam int VCW = (VN <= 2) ? 1 : $clog2(VN)
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [DW-1:0]  d_in,
    input  logic [VCW-1:0] vc_in,
    input  logic           req_in,
    output logic           ack_in,
    output logic [DW-1:0]  d_out,
    output logic [VCW-1:0] vc_out,
    output logic           req_out,
    input  logic           ack_out
`ifdef FIFO_VC_STATUS_EN
    ,
    output logic [VN-1:0]  full,
    output logic [VN-1:0]  empty
`endif
);

    localparam int PW = (L <= 2) ? 1 : $clog2(L);
    localparam int CW = $clog2(L + 1);

    logic [DW-1:0]  mem_q   [VN][L];
    logic [PW-1:0]  rptr_q  [VN];
    logic [PW-1:0]  rptr_d  [VN];
    logic [PW-1:0]  wptr_q  [VN];
    logic [PW-1:0]  wptr_d  [VN];
    logic [CW-1:0]  cnt_q   [VN];
    logic [CW-1:0]  cnt_d   [VN];
    logic [VCW-1:0] rr_ptr_q, rr_ptr_d;
    logic [VCW-1:0] lock_vc_q;
    logic           lock_q, lock_d;
    logic [VCW-1:0] gnt_vc, scan_idx;
    logic           in_range, push, pop;

    assign in_range = int'(vc_in) < VN;
    assign ack_in   = rstn & in_range & (cnt_q[vc_in] != CW'(L));
    assign push     = req_in & ack_in;

    // While locked the grant is frozen; otherwise the lowest offset from rr_ptr wins.
    always_comb begin
        gnt_vc   = rr_ptr_q;
        scan_idx = '0;
        if (lock_q) begin
            gnt_vc = lock_vc_q;
        end else begin
            for (int k = VN - 1; k >= 0; k--) begin
                scan_idx = VCW'((int'(rr_ptr_q) + k) % VN);
                if (cnt_q[scan_idx] != '0) gnt_vc = scan_idx;
            end
        end
    end

    assign req_out = rstn & (cnt_q[gnt_vc] != '0);
    assign vc_out  = gnt_vc;
    assign d_out   = mem_q[gnt_vc][rptr_q[gnt_vc]];
    assign pop     = req_out & ack_out;

    always_comb begin
        for (int c = 0; c < VN; c++) begin
            rptr_d[c] = rptr_q[c];
            wptr_d[c] = wptr_q[c];
            cnt_d[c]  = cnt_q[c];
            if (push && (vc_in == VCW'(c)))
                wptr_d[c] = (wptr_q[c] == PW'(L - 1)) ? '0 : wptr_q[c] + 1'b1;
            if (pop && (gnt_vc == VCW'(c)))
                rptr_d[c] = (rptr_q[c] == PW'(L - 1)) ? '0 : rptr_q[c] + 1'b1;
            case ({push && (vc_in == VCW'(c)), pop && (gnt_vc == VCW'(c))})
                2'b10:   cnt_d[c] = cnt_q[c] + 1'b1;
                2'b01:   cnt_d[c] = cnt_q[c] - 1'b1;
                default: cnt_d[c] = cnt_q[c];
            endcase
        end
        rr_ptr_d = pop ? VCW'((int'(gnt_vc) + 1) % VN) : rr_ptr_q;
        lock_d   = req_out & ~ack_out;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < VN; c++) begin
                rptr_q[c] <= '0;
                wptr_q[c] <= '0;
                cnt_q[c]  <= '0;
            end
            rr_ptr_q  <= '0;
            lock_q    <= 1'b0;
            lock_vc_q <= '0;
        end else begin
            for (int c = 0; c < VN; c++) begin
                rptr_q[c] <= rptr_d[c];
                wptr_q[c] <= wptr_d[c];
                cnt_q[c]  <= cnt_d[c];
            end
            rr_ptr_q  <= rr_ptr_d;
            lock_q    <= lock_d;
            lock_vc_q <= gnt_vc;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[vc_in][wptr_q[vc_in]] <= d_in;
    end

`ifdef FIFO_VC_STATUS_EN
    for (genvar c = 0; c < VN; c++) begin : g_status
        assign full[c]  = (cnt_q[c] == CW'(L));
        assign empty[c] = (cnt_q[c] == '0);
    end
`endif

endmodule

// File: tb/tb_fifo_vc_rr.sv
// tb/tb_fifo_vc_rr.sv - directed and scoreboarded checks of fifo_vc_rr (DW=16, L=8, VN=4)
module tb_fifo_vc_rr;
    localparam int DW = 16;
    localparam int L  = 8;
    localparam int VN = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [DW-1:0] d_in = '0;
    logic [1:0]    vc_in = '0;
    logic          req_in = 1'b0;
    logic          ack_out = 1'b0;
    logic          ack_in, req_out;
    logic [DW-1:0] d_out;
    logic [1:0]    vc_out;
`ifdef FIFO_VC_STATUS_EN
    logic [VN-1:0] full, empty;
`endif

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] q [VN][$];
    int            m_rr, m_lvc, g;
    bit            m_lock, exp_ack, exp_req;

    always #5 clk = ~clk;

    fifo_vc_rr #(.DW(DW), .L(L), .VN(VN)) dut (
        .clk(clk), .rstn(rstn), .d_in(d_in), .vc_in(vc_in), .req_in(req_in),
        .ack_in(ack_in), .d_out(d_out), .vc_out(vc_out), .req_out(req_out),
        .ack_out(ack_out)
`ifdef FIFO_VC_STATUS_EN
        , .full(full), .empty(empty)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int v, input logic [DW-1:0] d);
        vc_in  = 2'(v);
        d_in   = d;
        req_in = 1'b1;
        #1 chk("wr_ack_in", 32'(ack_in), 32'd1);
        tick();
        req_in = 1'b0;
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_req_out", 32'(req_out), 32'd0);
        chk("rst_ack_in", 32'(ack_in), 32'd0);
`ifdef FIFO_VC_STATUS_EN
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_empty", 32'(empty), 32'hF);
`endif
        #10 rstn = 1'b1;
        #1;
        chk("post_rst_ack_in", 32'(ack_in), 32'd1);
        chk("post_rst_req_out", 32'(req_out), 32'd0);
        tick();

        // one word per channel, drained in round-robin order
        ack_out = 1'b0;
        for (int i = 0; i < 4; i++) wr(i, 16'h00A0 + 16'(i));
        ack_out = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_req_out", 32'(req_out), 32'd1);
            chk("rr_vc_out", 32'(vc_out), 32'(i));
            chk("rr_d_out", 32'(d_out), 32'h00A0 + 32'(i));
            tick();
        end
        #1 chk("rr_empty_req_out", 32'(req_out), 32'd0);
        ack_out = 1'b0;

        // grant lock holds vc 2 although vc 0 is ahead in the scan
        wr(2, 16'h0022);
        #1;
        chk("lock_first_vc", 32'(vc_out), 32'd2);
        chk("lock_first_d", 32'(d_out), 32'h0022);
        wr(0, 16'h0000);
        #1;
        chk("lock_hold_vc", 32'(vc_out), 32'd2);
        chk("lock_hold_d", 32'(d_out), 32'h0022);
        tick();
        chk("lock_hold2_vc", 32'(vc_out), 32'd2);
        ack_out = 1'b1;
        #1 tick();
        chk("lock_next_req", 32'(req_out), 32'd1);
        chk("lock_next_vc", 32'(vc_out), 32'd0);
        chk("lock_next_d", 32'(d_out), 32'h0000);
        tick();
        chk("lock_drained", 32'(req_out), 32'd0);
        ack_out = 1'b0;

        // fill vc 1, refuse the ninth word, push+pop on full channel
        for (int i = 0; i < 8; i++) wr(1, 16'h0100 + 16'(i));
        vc_in  = 2'd1;
        d_in   = 16'hBEEF;
        req_in = 1'b1;
        #1 chk("full_vc1_ack", 32'(ack_in), 32'd0);
`ifdef FIFO_VC_STATUS_EN
        chk("full1_set", 32'(full[1]), 32'd1);
`endif
        vc_in = 2'd2;
        #1 chk("other_vc_ack", 32'(ack_in), 32'd1);
        vc_in   = 2'd1;
        ack_out = 1'b1;
        #1;
        chk("pushpop_ack_in", 32'(ack_in), 32'd0);
        chk("pushpop_vc", 32'(vc_out), 32'd1);
        chk("pushpop_d", 32'(d_out), 32'h0100);
        tick();
        req_in  = 1'b0;
        ack_out = 1'b0;
        #1 chk("after_pop_ack", 32'(ack_in), 32'd1);
`ifdef FIFO_VC_STATUS_EN
        chk("full1_clear", 32'(full[1]), 32'd0);
`endif
        wr(1, 16'h0108);
        #1 chk("refill_full_ack", 32'(ack_in), 32'd0);
        ack_out = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("vc1_drain_vc", 32'(vc_out), 32'd1);
            chk("vc1_drain_d", 32'(d_out), 32'h0101 + 32'(i));
            tick();
        end
        #1 chk("vc1_drained", 32'(req_out), 32'd0);
        ack_out = 1'b0;

        // asynchronous reset mid-transfer discards stored words
        for (int i = 0; i < 5; i++) wr(0, 16'h0500 + 16'(i));
        #1 chk("pre_arst_req", 32'(req_out), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("arst_req_out", 32'(req_out), 32'd0);
        chk("arst_ack_in", 32'(ack_in), 32'd0);
        tick();
        #2 rstn = 1'b1;
        #1;
        chk("arst_rel_req", 32'(req_out), 32'd0);
        chk("arst_rel_ack", 32'(ack_in), 32'd1);
        for (int i = 0; i < 8; i++) wr(0, 16'h0800 + 16'(i));
        #1 chk("arst_refill_full", 32'(ack_in), 32'd0);
        ack_out = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1 chk("arst_drain_d", 32'(d_out), 32'h0800 + 32'(i));
            tick();
        end
        #1 chk("arst_drained", 32'(req_out), 32'd0);
        ack_out = 1'b0;

        // random traffic against a reference model
        rstn = 1'b0;
        #1 rstn = 1'b1;
        m_rr   = 0;
        m_lvc  = 0;
        m_lock = 1'b0;
        tick();
        for (int cyc = 0; cyc < 1000; cyc++) begin
            req_in  = ($urandom_range(0, 2) != 0);
            vc_in   = 2'($urandom_range(0, 3));
            d_in    = 16'($urandom);
            ack_out = ($urandom_range(0, 3) != 0);
            if (cyc == 100) begin req_in = 1'b1; vc_in = 2'd3; d_in = 16'h1111; end
            if (cyc == 400) begin req_in = 1'b1; vc_in = 2'd3; d_in = 16'h2222; end
            if (cyc == 700) begin req_in = 1'b1; vc_in = 2'd3; d_in = 16'h3333; end
            #1;
            exp_ack = (q[vc_in].size() < L);
            if (m_lock) begin
                g = m_lvc;
            end else begin
                g = m_rr;
                for (int k = 3; k >= 0; k--)
                    if (q[(m_rr + k) % VN].size() != 0) g = (m_rr + k) % VN;
            end
            exp_req = (q[g].size() != 0);
            chk("rnd_ack_in", 32'(ack_in), 32'(exp_ack));
            chk("rnd_req_out", 32'(req_out), 32'(exp_req));
            if (exp_req) begin
                chk("rnd_vc_out", 32'(vc_out), 32'(g));
                chk("rnd_d_out", 32'(d_out), 32'(q[g][0]));
            end
            if (exp_req && ack_out) begin
                void'(q[g].pop_front());
                m_rr   = (g + 1) % VN;
                m_lock = 1'b0;
            end else begin
                m_lock = exp_req;
            end
            m_lvc = g;
            if (req_in && exp_ack) q[vc_in].push_back(d_in);
            tick();
        end
        req_in  = 1'b0;
        ack_out = 1'b1;
        for (int n = 0; n < 40 && req_out; n++) tick();
        chk("rnd_drain_done", 32'(req_out), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
